// File: rtl/uart_rx8.sv
// uart_rx8: receives the fixed 8-byte 8N1 frame from tx8 and republishes it
// as d0..d7 in one atomic update with a single-cycle frame_valid pulse.
// A framing error or an over-long idle gap inside a frame drops the partial
// frame and pulses frame_err so byte 0 stays aligned.
module uart_rx8 #(
  parameter int CLKFREQ  = 50000000,
  parameter int BAUD     = 115200,
  parameter int GAP_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_rx,
  output logic [7:0] d0,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [7:0] d3,
  output logic [7:0] d4,
  output logic [7:0] d5,
  output logic [7:0] d6,
  output logic [7:0] d7,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam int          BAUD_CLK = CLKFREQ / BAUD;
  localparam logic [15:0] HALF     = 16'(BAUD_CLK / 2);
  localparam logic [15:0] LAST     = 16'(BAUD_CLK - 1);
  localparam logic [31:0] GAP_LIM  = 32'(GAP_BITS * BAUD_CLK);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [2:0]  byte_idx;
  logic [31:0] gap_cnt;
  logic [7:0]  shadow [8];

  logic rx;
  logic start_edge;
  assign rx         = rx_s2;
  assign start_edge = rx_prev & ~rx_s2;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= UART_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receive FSM, byte/frame assembly and gap timeout, all outputs registered.
  // START samples at half a bit; every later sample lands one full bit after
  // the previous one (baud_cnt == LAST), i.e. mid-bit, since the counter is
  // rebased at the mid-start-bit sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      byte_idx    <= '0;
      gap_cnt     <= '0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
      d0 <= '0; d1 <= '0; d2 <= '0; d3 <= '0;
      d4 <= '0; d5 <= '0; d6 <= '0; d7 <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          // Gap timer only matters while a frame is partially received.
          if (byte_idx != 3'd0) begin
            if (gap_cnt == GAP_LIM) begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
              gap_cnt   <= '0;
            end else begin
              gap_cnt <= gap_cnt + 32'd1;
            end
          end else begin
            gap_cnt <= '0;
          end
          // A coincident timeout has already zeroed byte_idx, so the new
          // byte becomes byte 0.
          if (start_edge) begin
            state   <= START;
            gap_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt == LAST) begin
            baud_cnt <= '0;
            shift    <= {rx, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_cnt == LAST) begin
            baud_cnt <= '0;
            if (rx) begin
              state            <= IDLE;
              shadow[byte_idx] <= shift;
              byte_idx         <= byte_idx + 3'd1;
              if (byte_idx == 3'd7) begin
                d0 <= shadow[0]; d1 <= shadow[1]; d2 <= shadow[2]; d3 <= shadow[3];
                d4 <= shadow[4]; d5 <= shadow[5]; d6 <= shadow[6]; d7 <= shift;
                frame_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
              state     <= BRK;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        BRK: begin
          // Hold off until the line is high so a break is not a false start.
          baud_cnt <= '0;
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx8.sv
// Directed bench for uart_rx8: table of nominal frames plus hand-written
// sequences for glitch, framing error, gap timeout and mid-frame reset.
module tb_uart_rx8;
  localparam int CLKFREQ  = 1000000;
  localparam int BAUD     = 62500;
  localparam int GAP_BITS = 16;
  localparam int BC       = CLKFREQ / BAUD;   // 16 clocks per bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b0;
  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic fv, fe;

  uart_rx8 #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .GAP_BITS(GAP_BITS)) dut (
    .clk(clk), .rst(rst), .UART_rx(line),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .frame_valid(fv), .frame_err(fe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  int fv_cnt = 0, fe_cnt = 0, both_cnt = 0, fv_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (fv) begin fv_cnt++; fv_cyc = cyc; end
      if (fe) fe_cnt++;
      if (fv && fe) both_cnt++;
    end
  end

  int checks = 0, errors = 0;
  int stop_cyc = 0;

  typedef struct {
    string       name;
    logic [63:0] bytes;    // byte 0 in [63:56]
    logic [63:0] exp_d;    // expected {d0..d7}
    int          exp_fv;
    int          exp_fe;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] dvec();
    return {d0, d1, d2, d3, d4, d5, d6, d7};
  endfunction

  task automatic send_bit(input logic v);
    @(negedge clk);
    line = v;
    repeat (BC - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    @(negedge clk);
    line = stopv;
    stop_cyc = cyc;
    repeat (BC - 1) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    for (int i = 0; i < bits; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send_byte(f[63 - 8*i -: 8], 1'b1);
  endtask

  // Sends a full frame and checks data, pulse counts and valid latency.
  task automatic frame_check(input string nm, input logic [63:0] f);
    int fv0, fe0, lat;
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame(f);
    idle(2);
    chk({nm, "_d"}, dvec(), f);
    chk({nm, "_fv"}, 64'(fv_cnt - fv0), 64'd1);
    chk({nm, "_fe"}, 64'(fe_cnt - fe0), 64'd0);
    lat = fv_cyc - stop_cyc;
    checks++;
    if (lat < BC/2 || lat > BC/2 + 5) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles expected %0d..%0d", nm, lat, BC/2, BC/2 + 5);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int fv0, fe0;

    // T1: reset with line held low
    repeat (5) @(negedge clk);
    chk("reset_d", dvec(), 64'h0);
    chk("reset_fv", 64'(fv), 64'd0);
    chk("reset_fe", 64'(fe), 64'd0);
    line = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("post_reset_pulses", 64'(fv_cnt + fe_cnt), 64'd0);

    // Nominal frames (T2 and assorted patterns)
    vecs[0] = '{"t2_nominal", 64'h1122334455667788, 64'h1122334455667788, 1, 0};
    vecs[1] = '{"pat_ends",   64'h00FF55AA0180FE7F, 64'h00FF55AA0180FE7F, 1, 0};
    vecs[2] = '{"pat_ones",   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 0};
    vecs[3] = '{"pat_mixed",  64'hDEADBEEF12345678, 64'hDEADBEEF12345678, 1, 0};
    for (int v = 0; v < 4; v++) begin
      fv0 = fv_cnt; fe0 = fe_cnt;
      send_frame(vecs[v].bytes);
      idle(2);
      chk({vecs[v].name, "_d"}, dvec(), vecs[v].exp_d);
      chk({vecs[v].name, "_fv"}, 64'(fv_cnt - fv0), 64'(vecs[v].exp_fv));
      chk({vecs[v].name, "_fe"}, 64'(fe_cnt - fe0), 64'(vecs[v].exp_fe));
    end
    frame_check("t2_latency", 64'h1122334455667788);

    // T3: short glitch on idle line, then a good frame
    fv0 = fv_cnt; fe0 = fe_cnt;
    @(negedge clk); line = 1'b0;
    repeat (BC/4) @(negedge clk);
    line = 1'b1;
    idle(3);
    chk("t3_glitch_pulses", 64'(fv_cnt - fv0 + fe_cnt - fe0), 64'd0);
    chk("t3_glitch_d", dvec(), 64'h1122334455667788);
    frame_check("t3_after", 64'h3132333435363738);

    // T4: framing error on byte 3
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    idle(2);
    chk("t4_fe", 64'(fe_cnt - fe0), 64'd1);
    chk("t4_fv", 64'(fv_cnt - fv0), 64'd0);
    chk("t4_d_hold", dvec(), 64'h3132333435363738);
    frame_check("t4_resync", 64'hA0A1A2A3A4A5A6A7);

    // Gap shorter than the timeout inside a frame must not break it
    fv0 = fv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    idle(12);
    for (int i = 3; i < 8; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    idle(2);
    chk("short_gap_d", dvec(), 64'hC0C1C2C3C4C5C6C7);
    chk("short_gap_fv", 64'(fv_cnt - fv0), 64'd1);
    chk("short_gap_fe", 64'(fe_cnt - fe0), 64'd0);

    // T5: 5 bytes then a long idle gap
    fv0 = fv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b1);
    idle(20);
    chk("t5_fe", 64'(fe_cnt - fe0), 64'd1);
    chk("t5_fv", 64'(fv_cnt - fv0), 64'd0);
    chk("t5_d_hold", dvec(), 64'hC0C1C2C3C4C5C6C7);
    frame_check("t5_resync", 64'h0102030405060708);

    // T6: reset in the middle of byte 4
    fv0 = fv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i), 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_d", dvec(), 64'h0);
    chk("t6_rst_fv", 64'(fv), 64'd0);
    chk("t6_rst_fe", 64'(fe), 64'd0);
    line = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("t6_no_pulses", 64'(fv_cnt - fv0 + fe_cnt - fe0), 64'd0);
    frame_check("t6_after", 64'h1122334455667788);

    chk("never_both", 64'(both_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
